regfile16x16: RTL and testbench

16-entry × 16-bit register file that sits directly downstream of the 4-to-16 write-select demux (`demux16_1bit`). It consumes the demux's one-hot output as its per-register write strobe. It provides two synchronous read ports with write-first bypass. It also flags illegal (non-one-hot) select patterns instead of corrupting state.

---
 rtl/regfile16x16_if.sv | 22 ++
 rtl/regfile16x16.sv | 54 +++++
 tb/tb_regfile16x16.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/regfile16x16_if.sv
// Write/read bus between the write-select demux side and the 16x16 register file.
interface regfile16x16_if;
  logic        we;
  logic [15:0] wsel;
  logic [15:0] wdata;
  logic [3:0]  raddr_a;
  logic [3:0]  raddr_b;
  logic        err_clr;
  logic [15:0] rdata_a;
  logic [15:0] rdata_b;
  logic        wsel_err;

  modport master (
    output we, wsel, wdata, raddr_a, raddr_b, err_clr,
    input  rdata_a, rdata_b, wsel_err
  );

  modport slave (
    input  we, wsel, wdata, raddr_a, raddr_b, err_clr,
    output rdata_a, rdata_b, wsel_err
  );
endinterface

// File: rtl/regfile16x16.sv
// 16x16 register file: one-hot write strobe, R0 hardwired zero, two registered
// read ports with write-first bypass, sticky flag for non-one-hot write selects.
module regfile16x16 (
  input  logic           clk,
  input  logic           rst_n,
  regfile16x16_if.slave  rf
);
  logic [15:0] mem_q [16];
  logic [15:0] rdata_a_q, rdata_a_d;
  logic [15:0] rdata_b_q, rdata_b_d;
  logic        wsel_err_q, wsel_err_d;
  logic        onehot, wr_ok, wr_bad;
  logic        byp_a, byp_b;

  always_comb begin
    onehot = (rf.wsel != 16'h0000) && ((rf.wsel & (rf.wsel - 16'd1)) == 16'h0000);
    wr_ok  = rf.we && onehot;
    wr_bad = rf.we && !onehot;
    // Bypass only for a legal write that actually lands; R0 never bypasses.
    byp_a  = wr_ok && rf.wsel[rf.raddr_a] && (rf.raddr_a != 4'd0);
    byp_b  = wr_ok && rf.wsel[rf.raddr_b] && (rf.raddr_b != 4'd0);
    rdata_a_d = 16'h0000;
    rdata_b_d = 16'h0000;
    if (byp_a)                  rdata_a_d = rf.wdata;
    else if (rf.raddr_a != 4'd0) rdata_a_d = mem_q[rf.raddr_a];
    if (byp_b)                  rdata_b_d = rf.wdata;
    else if (rf.raddr_b != 4'd0) rdata_b_d = mem_q[rf.raddr_b];
    // A new error beats a clear on the same edge.
    wsel_err_d = wsel_err_q;
    if (wr_bad)          wsel_err_d = 1'b1;
    else if (rf.err_clr) wsel_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 16'h0000;
      rdata_a_q  <= 16'h0000;
      rdata_b_q  <= 16'h0000;
      wsel_err_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        for (int i = 1; i < 16; i++)
          if (rf.wsel[i]) mem_q[i] <= rf.wdata;
      end
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      wsel_err_q <= wsel_err_d;
    end
  end

  assign rf.rdata_a  = rdata_a_q;
  assign rf.rdata_b  = rdata_b_q;
  assign rf.wsel_err = wsel_err_q;
endmodule

// File: tb/tb_regfile16x16.sv
// Directed bench for regfile16x16: reset, sweep, bypass, illegal selects,
// error-clear priority and asynchronous reset mid-stream.
module tb_regfile16x16;
  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  regfile16x16_if rf ();

  regfile16x16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs set before the call are captured at the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] sel, input logic [15:0] data);
    rf.we    = 1'b1;
    rf.wsel  = sel;
    rf.wdata = data;
    step();
    rf.we    = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n = 1'b0;
    rf.we = 1'b0; rf.wsel = 16'h0; rf.wdata = 16'h0;
    rf.raddr_a = 4'd0; rf.raddr_b = 4'd0; rf.err_clr = 1'b0;
    #12;
    chk("rst_rdata_a", rf.rdata_a, 16'h0000);
    chk("rst_rdata_b", rf.rdata_b, 16'h0000);
    chk("rst_err", {15'h0, rf.wsel_err}, 16'h0000);
    step();
    rst_n = 1'b1;

    // 1: every address reads zero after reset
    for (int a = 0; a < 16; a++) begin
      rf.raddr_a = a[3:0];
      rf.raddr_b = 4'(15 - a);
      step();
      chk($sformatf("rst_rd_a%0d", a), rf.rdata_a, 16'h0000);
      chk($sformatf("rst_rd_b%0d", a), rf.rdata_b, 16'h0000);
    end
    chk("rst_err_after", {15'h0, rf.wsel_err}, 16'h0000);

    // 2: sweep R1..R15, then attempt R0 write with read of R0 on the same edge
    rf.raddr_a = 4'd1; rf.raddr_b = 4'd1;
    for (int k = 1; k < 16; k++) wr(16'h1 << k, 16'hA500 + 16'(k));
    rf.raddr_a = 4'd0; rf.raddr_b = 4'd0;
    wr(16'h0001, 16'hFFFF);
    chk("r0_nobypass_a", rf.rdata_a, 16'h0000);
    chk("r0_write_noerr", {15'h0, rf.wsel_err}, 16'h0000);
    for (int k = 0; k < 16; k++) begin
      rf.raddr_a = k[3:0];
      rf.raddr_b = 4'(15 - k);
      step();
      chk($sformatf("sweep_a%0d", k), rf.rdata_a, (k == 0) ? 16'h0000 : 16'hA500 + 16'(k));
      chk($sformatf("sweep_b%0d", 15 - k), rf.rdata_b, (k == 15) ? 16'h0000 : 16'hA500 + 16'(15 - k));
    end

    // 3: write-first bypass on both ports
    rf.raddr_a = 4'd1; rf.raddr_b = 4'd2;
    wr(16'h0020, 16'h1111);
    rf.raddr_a = 4'd5; rf.raddr_b = 4'd5;
    wr(16'h0020, 16'h2222);
    chk("byp_a", rf.rdata_a, 16'h2222);
    chk("byp_b", rf.rdata_b, 16'h2222);
    step();
    chk("byp_hold_a", rf.rdata_a, 16'h2222);

    // 4: illegal selects leave storage alone and set the flag
    wr(16'h0000, 16'hDEAD);
    chk("err_zero_sel", {15'h0, rf.wsel_err}, 16'h0001);
    rf.raddr_a = 4'd4; rf.raddr_b = 4'd5;
    wr(16'h0030, 16'hDEAD);
    chk("err_two_sel", {15'h0, rf.wsel_err}, 16'h0001);
    chk("two_sel_nobyp_a", rf.rdata_a, 16'hA504);
    chk("two_sel_nobyp_b", rf.rdata_b, 16'h2222);
    step();
    chk("r4_kept", rf.rdata_a, 16'hA504);
    chk("r5_kept", rf.rdata_b, 16'h2222);
    rf.wsel = 16'h00FF;
    step();
    chk("we0_keeps_err1", {15'h0, rf.wsel_err}, 16'h0001);

    // 5: clear, then we=0 junk select, then clear vs. new error
    rf.err_clr = 1'b1;
    step();
    chk("clr_alone", {15'h0, rf.wsel_err}, 16'h0000);
    rf.err_clr = 1'b0;
    rf.wsel = 16'h00FF;
    step();
    chk("we0_keeps_err0", {15'h0, rf.wsel_err}, 16'h0000);
    rf.err_clr = 1'b1;
    wr(16'h0003, 16'hBEEF);
    chk("set_beats_clr", {15'h0, rf.wsel_err}, 16'h0001);
    step();
    chk("clr_after_set", {15'h0, rf.wsel_err}, 16'h0000);
    rf.err_clr = 1'b0;
    rf.raddr_a = 4'd1;
    step();
    chk("illegal_r1_kept", rf.rdata_a, 16'hA501);

    // 6: asynchronous reset between edges
    rf.raddr_a = 4'd7; rf.raddr_b = 4'd7;
    wr(16'h0080, 16'h7777);
    chk("r7_byp", rf.rdata_a, 16'h7777);
    rf.wsel = 16'h0000;
    wr(16'h0000, 16'h0000);
    chk("err_before_rst", {15'h0, rf.wsel_err}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rdata_a", rf.rdata_a, 16'h0000);
    chk("async_rdata_b", rf.rdata_b, 16'h0000);
    chk("async_err", {15'h0, rf.wsel_err}, 16'h0000);
    rf.we = 1'b1; rf.wsel = 16'h0080; rf.wdata = 16'h9999;
    step();
    rf.we = 1'b0;
    rst_n = 1'b1;
    rf.raddr_a = 4'd7; rf.raddr_b = 4'd5;
    step();
    chk("r7_after_rst", rf.rdata_a, 16'h0000);
    chk("r5_after_rst", rf.rdata_b, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
